// File: rtl/song_player_if.sv
// Control and song-table signals of the song player, grouped as one bundle.
// The master side (controller or bench) drives the playback controls and the
// ROM data. The slave side (the player) drives the ROM address, the tone
// output, the status flags and a debug copy of its FSM state.
//
// Control protocol: there is no valid/ready pair. start is a request that the
// player samples only while idle. stop is an abort that is honoured in any
// busy state. pause is a level that is honoured only while a note is playing.
// The ROM answers rom_addr with rom_note/rom_dur exactly one clock later.
interface song_player_if #(
  parameter int ADDR_W = 10,
  parameter int NOTE_W = 20,
  parameter int DUR_W  = 5
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              speaker;
  logic              busy;
  logic              done;
  logic [2:0]        state;

  modport master (
    output start, stop, pause, loop_en, rom_note, rom_dur,
    input  rom_addr, speaker, busy, done, state
  );

  modport slave (
    input  start, stop, pause, loop_en, rom_note, rom_dur,
    output rom_addr, speaker, busy, done, state
  );
endinterface

// File: rtl/song_player.sv
// Song player: walks a song table (note half-period, duration in eighth-note
// units) held in an external ROM with one cycle of read latency, and drives a
// square-wave speaker output. Supports pause, stop, looping and a done pulse.
// The interface instance must be built with the same ADDR_W/NOTE_W/DUR_W.
module song_player #(
  parameter int ADDR_W      = 10,
  parameter int NOTE_W      = 20,
  parameter int DUR_W       = 5,
  parameter int SONG_LEN    = 45,
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic         clk,
  input  logic         reset,
  song_player_if.slave bus
);

  // Beat counter only has to reach UNIT_CYCLES-1.
  localparam int BEAT_W = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(UNIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_PLAY   = 3'd3,
    S_PAUSED = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  dur_q;
  logic [NOTE_W-1:0] tone_q;
  logic [BEAT_W-1:0] beat_q;
  logic [DUR_W-1:0]  unit_q;
  logic              speaker_q;
  logic              busy_q;
  logic              done_q;

  logic at_last_step;
  logic is_tone;
  logic play_last;

  // Decodes shared by the step-advance and tone logic.
  assign at_last_step = (addr_q >= LAST_ADDR);
  assign is_tone      = (note_q >= NOTE_W'(2));
  assign play_last    = (beat_q == BEAT_LAST) && (unit_q == dur_q - DUR_W'(1));

  assign bus.rom_addr = addr_q;
  assign bus.speaker  = speaker_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.state    = state_q;

  // Playback FSM with all counters and outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      note_q    <= '0;
      dur_q     <= '0;
      tone_q    <= '0;
      beat_q    <= '0;
      unit_q    <= '0;
      speaker_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop && (state_q != S_IDLE)) begin
        // Abort wins over every other transition and never signals done.
        state_q   <= S_IDLE;
        addr_q    <= '0;
        tone_q    <= '0;
        beat_q    <= '0;
        unit_q    <= '0;
        speaker_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            addr_q    <= '0;
            speaker_q <= 1'b0;
            if (bus.start && !bus.stop) begin
              state_q <= S_FETCH;
              busy_q  <= 1'b1;
            end
          end

          // Address is stable for this cycle so the ROM data is valid in LOAD.
          S_FETCH: begin
            speaker_q <= 1'b0;
            state_q   <= S_LOAD;
          end

          S_LOAD: begin
            note_q    <= bus.rom_note;
            dur_q     <= bus.rom_dur;
            tone_q    <= '0;
            beat_q    <= '0;
            unit_q    <= '0;
            speaker_q <= 1'b0;
            if (bus.rom_dur == '0) begin
              // Zero-length step: advance without ever entering PLAY.
              if (!at_last_step) begin
                addr_q  <= addr_q + ADDR_W'(1);
                state_q <= S_FETCH;
              end else if (bus.loop_en) begin
                addr_q  <= '0;
                state_q <= S_FETCH;
              end else begin
                addr_q  <= '0;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              state_q <= S_PLAY;
            end
          end

          S_PLAY: begin
            if (play_last) begin
              // Step end has priority over pause; pause applies on next PLAY.
              tone_q    <= '0;
              beat_q    <= '0;
              unit_q    <= '0;
              speaker_q <= 1'b0;
              if (!at_last_step) begin
                addr_q  <= addr_q + ADDR_W'(1);
                state_q <= S_FETCH;
              end else if (bus.loop_en) begin
                addr_q  <= '0;
                state_q <= S_FETCH;
              end else begin
                addr_q  <= '0;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              // This cycle always counts toward the step duration.
              if (beat_q == BEAT_LAST) begin
                beat_q <= '0;
                unit_q <= unit_q + DUR_W'(1);
              end else begin
                beat_q <= beat_q + BEAT_W'(1);
              end
              if (bus.pause) begin
                state_q   <= S_PAUSED;
                speaker_q <= 1'b0;
              end else if (is_tone) begin
                if (tone_q == note_q - NOTE_W'(1)) begin
                  tone_q    <= '0;
                  speaker_q <= ~speaker_q;
                end else begin
                  tone_q <= tone_q + NOTE_W'(1);
                end
              end else begin
                speaker_q <= 1'b0;
              end
            end
          end

          // Counters hold; the tone phase restarts low on resume.
          S_PAUSED: begin
            speaker_q <= 1'b0;
            if (!bus.pause) begin
              state_q <= S_PLAY;
              tone_q  <= '0;
            end
          end

          default: begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            speaker_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player with a 3-step table and 4-cycle units.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_song_player;
  localparam int ADDR_W      = 4;
  localparam int NOTE_W      = 8;
  localparam int DUR_W       = 4;
  localparam int SONG_LEN    = 3;
  localparam int UNIT_CYCLES = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [NOTE_W-1:0] note_tab [SONG_LEN];
  logic [DUR_W-1:0]  dur_tab  [SONG_LEN];

  song_player_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

  song_player #(
    .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W),
    .SONG_LEN(SONG_LEN), .UNIT_CYCLES(UNIT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Song ROM model with one cycle of read latency
  always @(posedge clk) begin
    int idx;
    idx = int'(bus.rom_addr);
    if (idx < SONG_LEN) begin
      bus.rom_note <= note_tab[idx];
      bus.rom_dur  <= dur_tab[idx];
    end else begin
      bus.rom_note <= '0;
      bus.rom_dur  <= '0;
    end
  end

  // Packed view: state(3) speaker done busy addr(4)
  function automatic logic [9:0] pk(int st, int spk, int dn, int by, int ad);
    return {3'(st), 1'(spk), 1'(dn), 1'(by), 4'(ad)};
  endfunction

  function automatic logic [9:0] obs();
    return {bus.state, bus.speaker, bus.done, bus.busy, bus.rom_addr};
  endfunction

  task automatic load_table();
    note_tab[0] = 8'd3; dur_tab[0] = 4'd2;
    note_tab[1] = 8'd1; dur_tab[1] = 4'd1;
    note_tab[2] = 8'd2; dur_tab[2] = 4'd1;
  endtask

  task automatic test_reset();
    logic [9:0] ev;
    reset = 1'b1;
    @(negedge clk);
    ev = pk(0, 0, 0, 0, 0);
    checks++;
    if (obs() !== ev) begin
      errors++; $display("FAIL reset_held got=%h exp=%h (st,spk,done,busy,addr)", obs(), ev);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== ev) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", obs(), ev);
    end
  endtask

  task automatic test_basic();
    int est [24]; int espk [24]; int eadr [24];
    logic [9:0] ev;
    est  = '{1,2,3,3,3,3,3,3,3,3, 1,2,3,3,3,3, 1,2,3,3,3,3, 0,0};
    espk = '{0,0,0,0,0,1,1,1,0,0, 0,0,0,0,0,0, 0,0,0,0,1,1, 0,0};
    eadr = '{0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1, 2,2,2,2,2,2, 0,0};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ev = pk(est[i], espk[i], (i == 22) ? 1 : 0, (est[i] != 0) ? 1 : 0, eadr[i]);
      checks++;
      if (obs() !== ev) begin
        errors++; $display("FAIL basic[%0d] got=%h exp=%h", i, obs(), ev);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int est [11]; int espk [11]; int eadr [11];
    logic [9:0] ev;
    est  = '{1,2,3,3,3,3,3,3,3,3,1};
    espk = '{0,0,0,0,0,1,1,1,0,0,0};
    eadr = '{0,0,0,0,0,0,0,0,0,0,1};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ev = pk(est[i], espk[i], 0, 1, eadr[i]);
      checks++;
      if (obs() !== ev) begin
        errors++; $display("FAIL start_busy[%0d] got=%h exp=%h", i, obs(), ev);
      end
      bus.start = (i == 4) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    // Now in LOAD of step 1: abort
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    ev = pk(0, 0, 0, 0, 0);
    checks++;
    if (obs() !== ev) begin
      errors++; $display("FAIL stop_in_load got=%h exp=%h", obs(), ev);
    end
    @(negedge clk);
  endtask

  task automatic test_loop();
    logic [9:0] ev;
    bus.loop_en = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (i < 44) begin
        checks++;
        if (bus.done !== 1'b0) begin
          errors++; $display("FAIL loop_no_done[%0d] got=%0d exp=0", i, bus.done);
        end
      end
      if (i == 21 || i == 43) begin
        ev = pk(3, 1, 0, 1, 2);
        checks++;
        if (obs() !== ev) begin
          errors++; $display("FAIL loop_last_play[%0d] got=%h exp=%h", i, obs(), ev);
        end
      end
      if (i == 22 || i == 23) begin
        ev = pk((i == 22) ? 1 : 2, 0, 0, 1, 0);
        checks++;
        if (obs() !== ev) begin
          errors++; $display("FAIL loop_wrap[%0d] got=%h exp=%h", i, obs(), ev);
        end
      end
      if (i == 44) begin
        ev = pk(0, 0, 1, 0, 0);
        checks++;
        if (obs() !== ev) begin
          errors++; $display("FAIL loop_done got=%h exp=%h", obs(), ev);
        end
      end
      if (i == 25) bus.loop_en = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL loop_after_done got=%h exp=%h", obs(), pk(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_pause();
    int est [16]; int espk [16]; int eadr [16];
    logic [9:0] ev;
    est  = '{1,2,3,3,3,4,4,4,4,4,3,3,3,3,3,1};
    espk = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,0};
    eadr = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ev = pk(est[i], espk[i], 0, 1, eadr[i]);
      checks++;
      if (obs() !== ev) begin
        errors++; $display("FAIL pause[%0d] got=%h exp=%h", i, obs(), ev);
      end
      if (i == 4) bus.pause = 1'b1;
      if (i == 9) bus.pause = 1'b0;
      @(negedge clk);
    end
    // In LOAD of step 1: stop together with pause must still abort
    bus.stop  = 1'b1;
    bus.pause = 1'b1;
    @(negedge clk);
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL pause_stop got=%h exp=%h", obs(), pk(0, 0, 0, 0, 0));
    end
    @(negedge clk);
  endtask

  task automatic test_stop();
    logic [9:0] ev;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 12) begin
        ev = pk(3, 0, 0, 1, 1);
        checks++;
        if (obs() !== ev) begin
          errors++; $display("FAIL stop_step1 got=%h exp=%h", obs(), ev);
        end
      end
      if (i == 13) bus.stop = 1'b1;
      @(negedge clk);
    end
    bus.stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ev = pk(0, 0, 0, 0, 0);
      checks++;
      if (obs() !== ev) begin
        errors++; $display("FAIL stop_idle[%0d] got=%h exp=%h", i, obs(), ev);
      end
      @(negedge clk);
    end
    // Replay from step 0
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || i == 2 || i == 5) begin
        ev = pk((i == 0) ? 1 : 3, (i == 5) ? 1 : 0, 0, 1, 0);
        checks++;
        if (obs() !== ev) begin
          errors++; $display("FAIL replay[%0d] got=%h exp=%h", i, obs(), ev);
        end
      end
      if (i < 5) @(negedge clk);
    end
    // Stop beats pause and start in PLAY
    bus.stop  = 1'b1;
    bus.pause = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.pause = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL stop_priority got=%h exp=%h", obs(), pk(0, 0, 0, 0, 0));
    end
    // start with stop while idle: stay idle
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL start_stop_idle got=%h exp=%h", obs(), pk(0, 0, 0, 0, 0));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [9:0] ev;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    ev = pk(3, 1, 0, 1, 0);
    checks++;
    if (obs() !== ev) begin
      errors++; $display("FAIL reset_mid_pre got=%h exp=%h", obs(), ev);
    end
    #2 reset = 1'b1;
    #1;
    ev = pk(0, 0, 0, 0, 0);
    checks++;
    if (obs() !== ev) begin
      errors++; $display("FAIL reset_mid_async got=%h exp=%h", obs(), ev);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== ev) begin
        errors++; $display("FAIL reset_mid_idle[%0d] got=%h exp=%h", i, obs(), ev);
      end
    end
  endtask

  task automatic test_skip();
    int est [20]; int espk [20]; int eadr [20];
    logic [9:0] ev;
    note_tab[1] = 8'd5;
    dur_tab[1]  = 4'd0;
    est  = '{1,2,3,3,3,3,3,3,3,3, 1,2,1,2,3,3,3,3, 0,0};
    espk = '{0,0,0,0,0,1,1,1,0,0, 0,0,0,0,0,0,1,1, 0,0};
    eadr = '{0,0,0,0,0,0,0,0,0,0, 1,1,2,2,2,2,2,2, 0,0};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ev = pk(est[i], espk[i], (i == 18) ? 1 : 0, (est[i] != 0) ? 1 : 0, eadr[i]);
      checks++;
      if (obs() !== ev) begin
        errors++; $display("FAIL skip[%0d] got=%h exp=%h", i, obs(), ev);
      end
      @(negedge clk);
    end
    load_table();
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pause   = 1'b0;
    bus.loop_en = 1'b0;
    load_table();
    test_reset();
    test_basic();
    test_start_ignored();
    test_loop();
    test_pause();
    test_stop();
    test_reset_mid();
    test_skip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 Parameters:
- ADDR_W, default 10: song ROM address width.
- NOTE_W, default 20: note half-period width, in clk cycles.
- DUR_W, default 5: duration width, in eighth-note units.
- SONG_LEN, default 45: number of table steps, range 1..2^ADDR_W.
- UNIT_CYCLES, default 12_500_000: clk cycles per eighth-note unit, minimum 2.
REQ-002 Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1: clock.
- reset, in, 1: asynchronous active-high reset.
- start, in, 1: begin playback from step 0; sampled only in IDLE.
- stop, in, 1: abort playback.
- pause, in, 1: level; hold playback while high.
- loop_en, in, 1: restart at step 0 after the last step.
- rom_addr, out, ADDR_W: song table address.
- rom_note, in, NOTE_W: half-period of the note at rom_addr.
- rom_dur, in, DUR_W: duration of the note at rom_addr.
- speaker, out, 1: square-wave tone output.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at natural song end.

Function
REQ-003 FSM states are IDLE, FETCH, LOAD, PLAY and PAUSED; all state, counters and outputs are registered.
REQ-004 IDLE: rom_addr=0, speaker=0, busy=0; start=1 and stop=0 -> FETCH next cycle.
REQ-005 FETCH: lasts exactly 1 cycle with rom_addr held stable (ROM has 1-cycle read latency); -> LOAD.
REQ-006 LOAD: captures rom_note and rom_dur; clears tone, unit and beat counters; speaker=0; -> PLAY. If rom_dur=0 the step is skipped and LOAD applies the REQ-009 advance rule directly.
REQ-007 PLAY tone: if the captured note >=2, speaker toggles every note cycles, starting from 0. If note is 0 or 1, the step is a rest and speaker holds 0.
REQ-008 PLAY timing: the step lasts exactly dur*UNIT_CYCLES cycles. Use a beat counter 0..UNIT_CYCLES-1 and a unit counter 0..dur-1; widths must not overflow.
REQ-009 Step end (last PLAY cycle):
- If rom_addr < SONG_LEN-1: rom_addr+1 -> FETCH.
- Else if loop_en=1: rom_addr=0 -> FETCH, no done pulse.
- Else: done=1 for 1 cycle -> IDLE.
REQ-010 loop_en is sampled only at the last-step end.
REQ-011 Between consecutive steps, speaker is 0 for exactly 2 cycles (FETCH and LOAD).
REQ-012 pause=1 in PLAY -> PAUSED next cycle. In PAUSED all counters freeze and speaker=0. pause=0 -> PLAY, resuming the counts; the tone phase restarts with speaker=0. pause has no effect in IDLE, FETCH or LOAD (it takes effect on PLAY entry).
REQ-013 stop=1 in any non-IDLE state -> IDLE next cycle: speaker=0, rom_addr=0, no done pulse. stop has priority over pause, start and the step-end transition.
REQ-014 start while busy=1 is ignored. start and stop high together in IDLE: remain in IDLE.
REQ-015 Playback begins: busy=1 the cycle after start is sampled; the first speaker activity can occur no earlier than 3 cycles after the start edge.

Reset
REQ-016 reset=1 asynchronously forces: IDLE, rom_addr=0, speaker=0, busy=0, done=0, all counters 0.
REQ-017 reset asserted mid-song aborts playback without a done pulse. After release the block waits for a new start.

Verification
REQ-018 Use UNIT_CYCLES=4, SONG_LEN=3, table {(3,2),(1,1),(2,1)}. Pulse start -> FETCH, LOAD, then 8 PLAY cycles with speaker 0,0,0,1,1,1,0,0. Then 2 gap cycles at 0, then 4 rest cycles at 0. Then 2 gap cycles, then 4 cycles at 0,0,1,1. Then done=1 for one cycle, then busy=0.
REQ-019 Same table with loop_en=1 -> after step 2, rom_addr returns to 0 with no done pulse. Drop loop_en during the second pass -> done pulses at the end of that pass.
REQ-020 pause=1 for 5 cycles during step 0 PLAY -> speaker=0 and the counters hold for 5 cycles. After release, step 0's total PLAY time is still 8 cycles, excluding the PAUSED cycles.
REQ-021 Assert stop during step 1 -> busy=0 and rom_addr=0 next cycle, with no done pulse. A later start replays from step 0.
REQ-022 Assert reset asynchronously mid-note -> speaker=0 and busy=0 immediately. A start pulse during busy has no effect.
REQ-023 Table entry (5,0) at step 1 -> step 1 is skipped. Step 2's FETCH follows step 1's LOAD, and step 1 produces no speaker activity.
